fetch_stage: RTL and testbench

Instruction-fetch stage of the LoongArch in-order pipeline: it owns the PC, issues reads on the instruction-SRAM request/response port, buffers one returned instruction and hands it to the decode stage over the fs→ds valid/allowin handshake. It consumes the decode stage's branch bus: it applies redirects, cancels wrong-path fetches and suppresses wrong-path handoff. At most one instruction-SRAM read is outstanding.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage: PC owner, single-outstanding inst-SRAM reader, one-entry      |
// | buffer toward decode. Optional FETCH_ADEF_EN raises ADEF on unaligned PCs. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_next_pc;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc;
    logic        r_buf_adef;
    logic        r_discard;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_adef;

    assign w_br_taken  = br_bus[32];
    assign w_br_target = br_bus[31:0];

`ifdef FETCH_ADEF_EN
    assign w_adef = (r_next_pc[1:0] != 2'b00);
`else
    assign w_adef = 1'b0;
`endif

    // No request is shown while reset is held, even though the state already reads REQ.
    assign inst_sram_req  = (r_state == S_REQ) & ~w_adef & ~reset;
    assign inst_sram_addr = {r_next_pc[31:2], 2'b00};
    assign fs_to_ds_valid = (r_state == S_HOLD) & ~w_br_taken;
    assign fs_to_ds_bus   = {r_buf_adef, r_buf_inst, r_buf_pc};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_next_pc  <= RESET_PC;
            r_fetch_pc <= 32'h0;
            r_buf_inst <= 32'h0;
            r_buf_pc   <= 32'h0;
            r_buf_adef <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            if (w_br_taken) begin
                r_next_pc <= w_br_target;
            end
            case (r_state)
                S_REQ: begin
                    if (w_adef) begin
                        if (!w_br_taken) begin
                            r_buf_inst <= 32'h0;
                            r_buf_pc   <= r_next_pc;
                            r_buf_adef <= 1'b1;
                            r_state    <= S_HOLD;
                        end
                    end else if (inst_sram_addr_ok) begin
                        r_fetch_pc <= r_next_pc;
                        r_state    <= S_WAIT;
                        if (w_br_taken) begin
                            r_discard <= 1'b1;
                        end else begin
                            r_next_pc <= r_next_pc + 32'd4;
                        end
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (r_discard || w_br_taken) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            r_buf_inst <= inst_sram_rdata;
                            r_buf_pc   <= r_fetch_pc;
                            r_buf_adef <= 1'b0;
                            r_state    <= S_HOLD;
                        end
                    end else if (w_br_taken) begin
                        r_discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect drops the buffered wrong-path instruction.
                    if (w_br_taken || ds_allowin) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage: randomized bench with an instruction-stream reference.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] c_reset_pc = 32'h1C00_0000;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    fetch_stage #(.RESET_PC(c_reset_pc)) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // drive knobs
    logic        drv_reset, drv_allowin, drv_br;
    logic [31:0] drv_target;
    bit          rand_mode, zero_wait, br_on_req, br_pulse, inject_stale;
    int          fixed_delay, br_hold;
    // memory model
    bit          sr_busy;
    int          sr_cnt;
    logic [31:0] sr_addr;
    // instruction-stream reference
    logic [31:0] exp_pc;
    bit          prev_stall, prev_reset;
    logic [64:0] prev_bus;
    int          idle, n_valid_seen;
    // per-cycle observations
    logic        o_req, o_aok, o_dok, o_valid;
    logic [31:0] o_addr;
    logic [64:0] o_bus;

    task automatic step();
        logic        aok, dok;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        reset = drv_reset;
        if (rand_mode) begin
            ds_allowin = ($urandom_range(3) != 0);
            if (br_hold == 0 && $urandom_range(11) == 0) begin
                br_hold    = $urandom_range(3, 1);
                drv_target = {16'h1C00, 14'($urandom_range(16383)), 2'b00};
            end
            drv_br = (br_hold != 0);
            if (br_hold != 0) br_hold--;
        end else begin
            ds_allowin = drv_allowin;
        end
        #1;
        o_req  = inst_sram_req;
        o_addr = inst_sram_addr;
        if (br_on_req && o_req) begin
            drv_br    = 1'b1;
            br_on_req = 1'b0;
            br_pulse  = 1'b1;
        end
        br_bus = {drv_br, drv_target};

        aok = 1'b0; dok = 1'b0; rd = 32'h0;
        if (inject_stale) begin
            dok = 1'b1; rd = 32'hDEAD_BEEF; inject_stale = 1'b0;
        end else if (sr_busy && sr_cnt == 0) begin
            dok = 1'b1; rd = mem_word(sr_addr);
        end
        if (o_req) begin
            check("one_outstanding", sr_busy, 1'b0);
            check("addr_aligned", o_addr[1:0], 2'b00);
            aok = !sr_busy && (zero_wait || $urandom_range(2) != 0);
        end
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rd;
        o_aok = aok; o_dok = dok;
        if (sr_busy) begin
            if (sr_cnt == 0) sr_busy = 1'b0;
            else sr_cnt--;
        end
        if (aok) begin
            sr_busy = 1'b1;
            sr_addr = o_addr;
            sr_cnt  = zero_wait ? 0 : (fixed_delay >= 0 ? fixed_delay : int'($urandom_range(3)));
        end
        if (drv_reset) sr_busy = 1'b0;
        #1;
        o_valid = fs_to_ds_valid;
        o_bus   = fs_to_ds_bus;

        if (drv_reset) begin
            check("rst_req", o_req, 1'b0);
            if (prev_reset) begin
                check("rst_valid", o_valid, 1'b0);
                check("rst_bus", o_bus, 65'h0);
            end
            exp_pc = c_reset_pc;
            prev_stall = 1'b0;
            idle = 0;
        end else begin
            if (o_valid) n_valid_seen++;
            if (prev_stall && !drv_br) begin
                check("hold_valid", o_valid, 1'b1);
                check("hold_bus", o_bus, prev_bus);
            end
            if (drv_br) begin
                check("br_valid", o_valid, 1'b0);
                exp_pc = drv_target;
                idle = 0;
            end else if (o_valid && ds_allowin) begin
`ifdef FETCH_ADEF_EN
                if (exp_pc[1:0] != 2'b00) begin
                    check("handoff_adef", o_bus, {1'b1, 32'h0, exp_pc});
                end else begin
                    check("handoff", o_bus, {1'b0, mem_word(exp_pc), exp_pc});
                    exp_pc = exp_pc + 32'd4;
                end
`else
                check("handoff", o_bus, {1'b0, mem_word(exp_pc), exp_pc});
                exp_pc = exp_pc + 32'd4;
`endif
                idle = 0;
            end else if (o_valid) begin
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 30) begin
                check("progress_idle_cycles", idle, 30);
                idle = 0;
            end
            prev_stall = o_valid && !ds_allowin && !drv_br;
            prev_bus   = o_bus;
        end
        prev_reset = drv_reset;
        if (br_pulse) begin
            drv_br   = 1'b0;
            br_pulse = 1'b0;
        end
    endtask

    task automatic do_reset();
        drv_reset = 1'b1;
        drv_br    = 1'b0;
        repeat (3) step();
        drv_reset = 1'b0;
    endtask

    task automatic wait_accept(output logic [31:0] a);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(o_req && o_aok) && n < 60);
        if (!(o_req && o_aok)) check("timeout_accept", n, 0);
        a = o_addr;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!o_valid && n < 60);
        if (!o_valid) check("timeout_valid", n, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          v0;
        reset = 1'b1; ds_allowin = 1'b0; br_bus = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        drv_reset = 1'b1; drv_allowin = 1'b1; drv_br = 1'b0; drv_target = '0;
        rand_mode = 1'b0; zero_wait = 1'b1; br_on_req = 1'b0; br_pulse = 1'b0;
        inject_stale = 1'b0; fixed_delay = -1; br_hold = 0;
        sr_busy = 1'b0; sr_cnt = 0; sr_addr = '0;
        exp_pc = c_reset_pc; prev_stall = 1'b0; prev_reset = 1'b0; prev_bus = '0;
        idle = 0; n_valid_seen = 0;

        // sequential fetch with zero-wait memory: REQ, WAIT, HOLD per instruction
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("seq_req%0d", i), o_req, 1'b1);
            check($sformatf("seq_addr%0d", i), o_addr, c_reset_pc + 32'(4 * i));
            step();
            check($sformatf("seq_wait_valid%0d", i), o_valid, 1'b0);
            step();
            check($sformatf("seq_valid%0d", i), o_valid, 1'b1);
            check($sformatf("seq_pc%0d", i), o_bus[31:0], c_reset_pc + 32'(4 * i));
        end

        // decode stalls for five cycles in HOLD
        do_reset();
        step(); step();
        drv_allowin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_valid%0d", i), o_valid, 1'b1);
            check($sformatf("stall_req%0d", i), o_req, 1'b0);
        end
        drv_allowin = 1'b1;
        step();
        step();
        check("stall_next_req", o_req, 1'b1);
        check("stall_next_addr", o_addr, 32'h1C00_0004);

        // redirect while a read is outstanding; its data must be dropped
        do_reset();
        zero_wait = 1'b0; fixed_delay = 3;
        wait_accept(a);
        v0 = n_valid_seen;
        drv_target = 32'h1C00_0100; drv_br = 1'b1;
        step();
        drv_br = 1'b0;
        wait_accept(a);
        check("wait_br_addr", a, 32'h1C00_0100);
        check("wait_br_no_valid", n_valid_seen - v0, 0);
        zero_wait = 1'b1; fixed_delay = -1;

        // redirect while holding pc 1C000008
        do_reset();
        repeat (6) step();
        drv_allowin = 1'b0;
        repeat (3) step();
        check("hold8_valid", o_valid, 1'b1);
        check("hold8_pc", o_bus[31:0], 32'h1C00_0008);
        drv_target = 32'h1C00_0200; drv_br = 1'b1;
        step();
        check("hold_br_valid", o_valid, 1'b0);
        drv_br = 1'b0; drv_allowin = 1'b1;
        step();
        check("hold_br_req", o_req, 1'b1);
        check("hold_br_addr", o_addr, 32'h1C00_0200);

        // redirect coincident with addr_ok
        do_reset();
        drv_target = 32'h1C00_0300; br_on_req = 1'b1;
        step(); step();
        step();
        check("coinc_req", o_req, 1'b1);
        check("coinc_addr", o_addr, 32'h1C00_0300);
        step(); step();
        check("coinc_valid", o_valid, 1'b1);
        check("coinc_pc", o_bus[31:0], 32'h1C00_0300);
        step();
        check("coinc_next_addr", o_addr, 32'h1C00_0304);

        // redirect to an unaligned target
        do_reset();
        drv_target = 32'h1C00_0102; drv_br = 1'b1;
        step();
        check("unal_first_req", o_req, 1'b1);
        drv_br = 1'b0;
        step();
        step();
`ifdef FETCH_ADEF_EN
        check("adef_no_req", o_req, 1'b0);
        step();
        check("adef_valid", o_valid, 1'b1);
        check("adef_bus", o_bus, {1'b1, 32'h0, 32'h1C00_0102});
`else
        check("unal_req", o_req, 1'b1);
        check("unal_addr", o_addr, 32'h1C00_0100);
        step(); step();
        check("unal_valid", o_valid, 1'b1);
        check("unal_adef", o_bus[64], 1'b0);
`endif

        // reset mid-read, then a stale data_ok in the first REQ cycle
        do_reset();
        zero_wait = 1'b0; fixed_delay = 3;
        wait_accept(a);
        step();
        do_reset();
        fixed_delay = -1;
        inject_stale = 1'b1;
        wait_valid();
        check("stale_bus", o_bus, {1'b0, mem_word(c_reset_pc), c_reset_pc});

        // randomized traffic against the instruction-stream reference
        do_reset();
        rand_mode = 1'b1; zero_wait = 1'b0;
        repeat (3000) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
